// File: rtl/cache_pkg.sv
// Shared types and sizing for the direct-mapped instruction cache.
// Contents: fetch op encoding, cache geometry, memory read-type codes and
// the latched-request payload carried from accept into LOOKUP and refill.
package cache_pkg;

    localparam int unsigned ICACHE_LINE_WORDS = 4;
    localparam int unsigned ICACHE_SETS       = 256;
    localparam int unsigned ICACHE_TAG_W      = 20;
    localparam int unsigned ICACHE_IDX_W      = 8;
    localparam int unsigned ICACHE_OFF_W      = 2;
    localparam int unsigned ICACHE_WORD_W     = 32;
    localparam int unsigned ICACHE_PA_WORD_W  = 30;
    localparam int unsigned ICACHE_LINE_W     = ICACHE_LINE_WORDS * ICACHE_WORD_W;

    localparam logic RD_WORD = 1'b0;
    localparam logic RD_LINE = 1'b1;

    typedef enum logic [2:0] {
        ICACHE_NOP     = 3'd0,
        ICACHE_FETCH   = 3'd1,
        ICACHE_IDX_INV = 3'd2,
        ICACHE_HIT_INV = 3'd3
    } icache_op_t;

    // Request as latched on accept; only the address bits the cache uses.
    typedef struct packed {
        icache_op_t                    op;
        logic                          is_cached;
        logic [ICACHE_IDX_W-1:0]       set;      // idx[11:4]
        logic [ICACHE_PA_WORD_W-1:0]   pa_word;  // pa[31:2]
    } icache_req_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side request/response bus of the instruction cache.
// master: Fetch1/Fetch2 (drives request, consumes word)
// slave : icache (accepts request, returns word)
interface icache_if;
    import cache_pkg::*;

    logic [11:0] icache_idx;
    icache_op_t  icache_op;
    logic        icache_is_cached;
    logic [31:0] icache_pa;
    logic        icache_ready;
    logic [31:0] icache_data;
    logic        icache_data_valid;
    logic        icache_data_ready;

    modport master (
        output icache_idx, icache_op, icache_is_cached, icache_pa, icache_data_ready,
        input  icache_ready, icache_data, icache_data_valid
    );

    modport slave (
        input  icache_idx, icache_op, icache_is_cached, icache_pa, icache_data_ready,
        output icache_ready, icache_data, icache_data_valid
    );

endinterface

// File: rtl/icache_ram.sv
// Synchronous single-port RAM with per-lane write enables.
// Ports: clk; addr; we (one bit per lane); wdata; rdata (registered read,
// old data on read-during-write).
module icache_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LANES  = 1,
    parameter int unsigned LANE_W = 20
) (
    input  logic                      clk,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [LANES-1:0]          we,
    input  logic [LANES*LANE_W-1:0]   wdata,
    output logic [LANES*LANE_W-1:0]   rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [LANES*LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (we[l]) begin
                mem[addr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped blocking instruction cache (256 sets x 4 words).
// Ports: clk, rst (async, active-high); fetch (icache_if.slave: request
// idx/op/pa/is_cached with ready, word response data/valid/ready);
// memory read port rd_req/rd_type/rd_addr/rd_rdy and return beats
// ret_valid/ret_last/ret_data.
// Build option ICACHE_PERF_CNT_EN adds perf_hit_cnt/perf_miss_cnt.
module icache
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    icache_if.slave     fetch,
    output logic        rd_req,
    output logic        rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_RESP} state_t;

    state_t                   state;
    icache_req_t              req;
    logic [ICACHE_SETS-1:0]   valid_q;
    logic [ICACHE_OFF_W-1:0]  beat_cnt;
    logic [ICACHE_WORD_W-1:0] resp_q;

    logic [ICACHE_IDX_W-1:0]      ram_addr;
    logic [ICACHE_TAG_W-1:0]      tag_rdata;
    logic [ICACHE_LINE_W-1:0]     data_rdata;
    logic                         tag_we;
    logic [ICACHE_LINE_WORDS-1:0] data_we;
    logic [ICACHE_WORD_W-1:0]     hit_word;
    logic                         tag_hit;
    logic                         lookup_fetch;
    logic                         fetch_hit;
    logic                         accept;
    logic                         ret_fire;
    logic                         unused_addr_bits;

    assign unused_addr_bits = ^{fetch.icache_pa[1:0], fetch.icache_idx[3:0]};

    // Tag compare against the RAM word read in the accept cycle.
    assign tag_hit      = valid_q[req.set] && (tag_rdata == req.pa_word[29:10]);
    assign lookup_fetch = (state == S_LOOKUP) && (req.op == ICACHE_FETCH);
    assign fetch_hit    = lookup_fetch && req.is_cached && tag_hit;
    assign hit_word     = data_rdata[{req.pa_word[1:0], 5'b00000} +: ICACHE_WORD_W];
    assign accept       = fetch.icache_ready && (fetch.icache_op != ICACHE_NOP);
    assign ret_fire     = (state == S_REFILL) && ret_valid;

    // Fetch-side handshake and RAM port steering.
    always_comb begin
        fetch.icache_ready      = 1'b0;
        fetch.icache_data_valid = 1'b0;
        fetch.icache_data       = resp_q;
        ram_addr                = req.set;
        tag_we                  = 1'b0;
        data_we                 = '0;

        fetch.icache_ready = (state == S_IDLE)
                           || (fetch_hit && fetch.icache_data_ready)
                           || ((state == S_RESP) && fetch.icache_data_ready);
        fetch.icache_data_valid = fetch_hit || (state == S_RESP);
        if (fetch_hit) begin
            fetch.icache_data = hit_word;
        end
        // New lookups read at the incoming index; otherwise hold the latched set.
        if (accept) begin
            ram_addr = fetch.icache_idx[11:4];
        end
        if (ret_fire && req.is_cached) begin
            data_we = ICACHE_LINE_WORDS'(1) << beat_cnt;
            tag_we  = ret_last;
        end
    end

    icache_ram #(.ADDR_W(ICACHE_IDX_W), .LANES(1), .LANE_W(ICACHE_TAG_W)) u_tag_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (tag_we),
        .wdata (req.pa_word[29:10]),
        .rdata (tag_rdata)
    );

    icache_ram #(.ADDR_W(ICACHE_IDX_W), .LANES(ICACHE_LINE_WORDS), .LANE_W(ICACHE_WORD_W)) u_data_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (data_we),
        .wdata ({ICACHE_LINE_WORDS{ret_data}}),
        .rdata (data_rdata)
    );

    // Control FSM, valid bits and memory request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            req      <= '0;
            valid_q  <= '0;
            beat_cnt <= '0;
            resp_q   <= '0;
            rd_req   <= 1'b0;
            rd_type  <= RD_WORD;
            rd_addr  <= '0;
        end else begin
            if (accept) begin
                req.op        <= fetch.icache_op;
                req.is_cached <= fetch.icache_is_cached;
                req.set       <= fetch.icache_idx[11:4];
                req.pa_word   <= fetch.icache_pa[31:2];
            end
            case (state)
                S_IDLE: begin
                    if (accept) state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    case (req.op)
                        ICACHE_FETCH: begin
                            if (!req.is_cached) begin
                                state   <= S_MISS;
                                rd_req  <= 1'b1;
                                rd_type <= RD_WORD;
                                rd_addr <= {req.pa_word, 2'b00};
                            end else if (tag_hit) begin
                                if (fetch.icache_data_ready) begin
                                    state <= accept ? S_LOOKUP : S_IDLE;
                                end else begin
                                    resp_q <= hit_word;
                                    state  <= S_RESP;
                                end
                            end else begin
                                state   <= S_MISS;
                                rd_req  <= 1'b1;
                                rd_type <= RD_LINE;
                                rd_addr <= {req.pa_word[29:2], 4'b0000};
                            end
                        end
                        ICACHE_IDX_INV: begin
                            valid_q[req.set] <= 1'b0;
                            state            <= S_IDLE;
                        end
                        ICACHE_HIT_INV: begin
                            if (tag_hit) valid_q[req.set] <= 1'b0;
                            state <= S_IDLE;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                S_MISS: begin
                    if (rd_rdy) begin
                        rd_req   <= 1'b0;
                        beat_cnt <= '0;
                        state    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (ret_valid) begin
                        beat_cnt <= ICACHE_OFF_W'(beat_cnt + 2'd1);
                        // Uncached returns exactly one beat: always the requested word.
                        if (!req.is_cached || (beat_cnt == req.pa_word[1:0])) begin
                            resp_q <= ret_data;
                        end
                        if (ret_last) begin
                            if (req.is_cached) valid_q[req.set] <= 1'b1;
                            state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (fetch.icache_data_ready) begin
                        state <= accept ? S_LOOKUP : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Cached FETCH outcome counters, sampled in LOOKUP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else if (lookup_fetch && req.is_cached) begin
            if (tag_hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
            else         perf_miss_cnt <= perf_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by random
// traffic, all checked by a line-level reference model on every cycle.
module tb_icache;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req, rd_type, rd_rdy, ret_valid, ret_last;
    logic [31:0] rd_addr, ret_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

    icache_if bif();

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (bif),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hit_cnt  (perf_hit_cnt),
        .perf_miss_cnt (perf_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Backing memory: line 0x1C000000.. returns 0xA0 + word index.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:12] == 20'h1C000) return 32'hA0 + 32'(a[11:2]);
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        bit          miss;
        bit          hs_done;
        logic        rtype;
        logic [31:0] raddr;
        int          age;
    } exp_t;

    exp_t        q[$];
    bit          hit_due, inv_due;
    bit          mv [256];
    logic [19:0] mt [256];
    int          rd_hs_cnt = 0;
    int          mdl_hit = 0, mdl_miss = 0;

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [7:0]  s;
        logic [19:0] t;
        logic [31:0] pa;
        logic        exp_rdy;
        if (rst) begin
            q.delete();
            hit_due = 0;
            inv_due = 0;
            mdl_hit = 0;
            mdl_miss = 0;
            foreach (mv[i]) mv[i] = 0;
        end else begin
            if (hit_due) chk("hit_latency", 32'(bif.icache_data_valid), 32'd1);
            if (bif.icache_data_valid) begin
                if (q.size() == 0) chk("spurious_valid", 32'(bif.icache_data_valid), 32'd0);
                else begin
                    chk("resp_before_refill", 32'(q[0].miss && !q[0].hs_done), 32'd0);
                    chk("resp_data", bif.icache_data, q[0].data);
                end
            end
            if (rd_req) begin
                if (q.size() == 0 || !q[0].miss || q[0].hs_done)
                    chk("spurious_rd_req", 32'(rd_req), 32'd0);
                else begin
                    chk("rd_type", 32'(rd_type), 32'(q[0].rtype));
                    chk("rd_addr", rd_addr, q[0].raddr);
                end
            end
            exp_rdy = (q.size() == 0) ? !inv_due : (bif.icache_data_valid && bif.icache_data_ready);
            chk("ready", 32'(bif.icache_ready), 32'(exp_rdy));
            if (q.size() > 0) begin
                q[0].age++;
                if (q[0].age > 300) begin
                    chk("resp_timeout", 32'(q[0].age), 32'd300);
                    void'(q.pop_front());
                end
            end
            // advance model by the handshakes happening at the coming edge
            if (bif.icache_data_valid && bif.icache_data_ready && q.size() > 0) void'(q.pop_front());
            if (rd_req && rd_rdy) begin
                rd_hs_cnt++;
                if (q.size() > 0) q[0].hs_done = 1;
            end
            hit_due = 0;
            inv_due = 0;
            if (bif.icache_ready && bif.icache_op != ICACHE_NOP) begin
                pa = bif.icache_pa;
                s  = bif.icache_idx[11:4];
                t  = pa[31:12];
                case (bif.icache_op)
                    ICACHE_FETCH: begin
                        e.data = mem_word({pa[31:2], 2'b00});
                        e.age = 0; e.hs_done = 0; e.rtype = 0; e.raddr = 0;
                        if (!bif.icache_is_cached) begin
                            e.miss = 1; e.rtype = RD_WORD; e.raddr = {pa[31:2], 2'b00};
                        end else if (mv[s] && mt[s] == t) begin
                            e.miss = 0; hit_due = 1; mdl_hit++;
                        end else begin
                            e.miss = 1; e.rtype = RD_LINE; e.raddr = {pa[31:4], 4'b0000};
                            mv[s] = 1; mt[s] = t; mdl_miss++;
                        end
                        q.push_back(e);
                    end
                    ICACHE_IDX_INV: begin mv[s] = 0; inv_due = 1; end
                    ICACHE_HIT_INV: begin
                        if (mv[s] && mt[s] == t) mv[s] = 0;
                        inv_due = 1;
                    end
                    default: inv_due = 1;
                endcase
            end
        end
    end

    // ---------------- memory responder ----------------
    logic [31:0] lat_addr;
    logic        lat_type;

    initial begin : mem_resp
        int nb;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
        lat_addr = 0; lat_type = 0;
        forever begin
            @(posedge clk); #1;
            if (rd_rdy) begin
                rd_rdy = 0;
                nb = lat_type ? 4 : 1;
                for (int b = 0; b < nb; b++) begin
                    while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    ret_valid = 1;
                    ret_last  = (b == nb - 1);
                    ret_data  = mem_word(lat_addr + 32'(b) * 32'd4);
                    @(posedge clk); #1;
                    ret_valid = 0;
                    ret_last  = 0;
                end
            end else if (rd_req) begin
                rd_rdy   = ($urandom_range(0, 2) != 0);
                lat_addr = rd_addr;
                lat_type = rd_type;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input icache_op_t op, input logic [31:0] pa, input logic cached);
        int n = 0;
        bif.icache_op = op;
        bif.icache_pa = pa;
        bif.icache_idx = pa[11:0];
        bif.icache_is_cached = cached;
        @(negedge clk);
        while (!bif.icache_ready && n < 200) begin @(negedge clk); n++; end
        chk("issue_accepted", 32'(bif.icache_ready), 32'd1);
        @(posedge clk); #1;
        bif.icache_op = ICACHE_NOP;
    endtask

    task automatic wait_rdreq(input logic exp_type, input logic [31:0] exp_addr);
        int n = 0;
        @(negedge clk);
        while (!rd_req && n < 50) begin @(negedge clk); n++; end
        chk("rd_req_seen", 32'(rd_req), 32'd1);
        chk("dir_rd_type", 32'(rd_type), 32'(exp_type));
        chk("dir_rd_addr", rd_addr, exp_addr);
    endtask

    task automatic wait_resp(output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!bif.icache_data_valid && n < 200) begin @(negedge clk); n++; end
        chk("resp_arrives", 32'(bif.icache_data_valid), 32'd1);
        d = bif.icache_data;
        @(posedge clk); #1;
    endtask

    logic [19:0] tags [4] = '{20'h1C000, 20'h1C001, 20'h1FE00, 20'h00ABC};

    initial begin : main
        logic [31:0] d;
        int hs, n, r;
        rst = 1;
        bif.icache_op = ICACHE_NOP; bif.icache_pa = 0; bif.icache_idx = 0;
        bif.icache_is_cached = 1; bif.icache_data_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bif.icache_ready), 32'd1);
        chk("rst_valid", 32'(bif.icache_data_valid), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_data", bif.icache_data, 32'd0);
        rst = 0;
        @(posedge clk); #1;

        // cold miss, line refill
        hs = rd_hs_cnt;
        issue(ICACHE_FETCH, 32'h1C000004, 1);
        wait_rdreq(1'b1, 32'h1C000000);
        wait_resp(d);
        chk("cold_data", d, 32'h000000A1);
        chk("cold_one_read", 32'(rd_hs_cnt), 32'(hs + 1));

        // four back-to-back hits
        hs = rd_hs_cnt;
        for (int k = 0; k < 4; k++) begin
            bif.icache_op = ICACHE_FETCH;
            bif.icache_pa = 32'h1C000000 + 32'(k) * 32'd4;
            bif.icache_idx = bif.icache_pa[11:0];
            bif.icache_is_cached = 1;
            @(negedge clk);
            chk("b2b_ready", 32'(bif.icache_ready), 32'd1);
            if (k > 0) begin
                chk("b2b_valid", 32'(bif.icache_data_valid), 32'd1);
                chk("b2b_data", bif.icache_data, 32'hA0 + 32'(k - 1));
            end
            @(posedge clk); #1;
        end
        bif.icache_op = ICACHE_NOP;
        @(negedge clk);
        chk("b2b_last_valid", 32'(bif.icache_data_valid), 32'd1);
        chk("b2b_last_data", bif.icache_data, 32'h000000A3);
        @(posedge clk); #1;
        chk("b2b_no_reads", 32'(rd_hs_cnt), 32'(hs));

        // hit stalled by Fetch2 for three cycles
        bif.icache_data_ready = 0;
        issue(ICACHE_FETCH, 32'h1C000008, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bif.icache_data_valid), 32'd1);
            chk("hold_data", bif.icache_data, 32'h000000A2);
            chk("hold_ready", 32'(bif.icache_ready), 32'd0);
            @(posedge clk); #1;
        end
        bif.icache_data_ready = 1;
        @(negedge clk);
        chk("hold_release_data", bif.icache_data, 32'h000000A2);
        chk("hold_release_ready", 32'(bif.icache_ready), 32'd1);
        @(posedge clk); #1;

        // uncached fetch, twice
        issue(ICACHE_FETCH, 32'h1FE00008, 0);
        wait_rdreq(1'b0, 32'h1FE00008);
        wait_resp(d);
        hs = rd_hs_cnt;
        issue(ICACHE_FETCH, 32'h1FE00008, 0);
        wait_resp(d);
        chk("uncached_refetch_misses", 32'(rd_hs_cnt), 32'(hs + 1));

        // IDX_INV drops the line
        issue(ICACHE_IDX_INV, 32'h1C000000, 1);
        repeat (2) @(posedge clk);
        #1;
        hs = rd_hs_cnt;
        issue(ICACHE_FETCH, 32'h1C000000, 1);
        wait_resp(d);
        chk("idx_inv_miss", 32'(rd_hs_cnt), 32'(hs + 1));

        // HIT_INV with a different tag leaves the line alone
        issue(ICACHE_HIT_INV, 32'h1D000000, 1);
        repeat (2) @(posedge clk);
        #1;
        hs = rd_hs_cnt;
        issue(ICACHE_FETCH, 32'h1C000000, 1);
        wait_resp(d);
        chk("hit_inv_mismatch_hit", 32'(rd_hs_cnt), 32'(hs));

        // reset during refill
        issue(ICACHE_FETCH, 32'h1C000010, 1);
        n = 0;
        @(negedge clk);
        while (!ret_valid && n < 100) begin @(negedge clk); n++; end
        chk("refill_started", 32'(ret_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("midrst_valid", 32'(bif.icache_data_valid), 32'd0);
        chk("midrst_ready", 32'(bif.icache_ready), 32'd1);
        chk("midrst_rd_req", 32'(rd_req), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("stray_valid", 32'(bif.icache_data_valid), 32'd0);
            chk("stray_ready", 32'(bif.icache_ready), 32'd1);
        end
        @(posedge clk); #1;
        hs = rd_hs_cnt;
        issue(ICACHE_FETCH, 32'h1C000000, 1);
        wait_resp(d);
        chk("post_reset_miss", 32'(rd_hs_cnt), 32'(hs + 1));
        chk("post_reset_data", d, 32'h000000A0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            bif.icache_op = (r < 2) ? ICACHE_NOP : (r == 2) ? ICACHE_IDX_INV :
                            (r == 3) ? ICACHE_HIT_INV : ICACHE_FETCH;
            bif.icache_pa = {tags[$urandom_range(0, 3)], 6'd0, 2'($urandom_range(0, 3)),
                             2'($urandom_range(0, 3)), 2'b00};
            bif.icache_idx = bif.icache_pa[11:0];
            bif.icache_is_cached = ($urandom_range(0, 7) != 0);
            bif.icache_data_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        bif.icache_op = ICACHE_NOP;
        bif.icache_data_ready = 1;
        n = 0;
        while (q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
        chk("drain", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hit", perf_hit_cnt, 32'(mdl_hit));
        chk("perf_miss", perf_miss_cnt, 32'(mdl_miss));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
